cast5_fround: RTL and testbench
===============================

// Module: cast5_fround
// PURPOSE
//  CAST5 round-function (f) datapath stage. Consumes D (right half) plus the per-round
//  subkeys Km/Kr, computes I = (Km op D) <<< Kr using cast5_rol, drives byte addresses
//  to four external S-box ROMs (S1..S4) and combines their outputs per round type into f.
//  Sits between the round sequencer/key-schedule (upstream) and the L^f swap logic
//  (downstream). Valid/ready on both sides; throughput one operation per clock.
// PARAMETERS
//  PIPE_I  1  1: registered I stage (latency 3); 0: I drives ROM addresses in the accept cycle (latency 2)
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  rst        in   1   synchronous reset, active-high
//  in_valid   in   1   input operation valid
//  in_ready   out  1   stage can accept this cycle
//  in_type    in   2   00=type1, 01=type2, 10=type3, 11 reserved (handled as type1)
//  in_d       in   32  data half D
//  in_km      in   32  masking subkey Km
//  in_kr      in   5   rotation subkey Kr (low 5 bits only)
//  s_en       out  1   S-box ROM read enable
//  s1_addr..s4_addr out 8 each  Ia..Id = I[31:24], I[23:16], I[15:8], I[7:0]
//  s1_data..s4_data in 32 each  ROM read data, valid the cycle after s_en; ROM holds output while s_en=0
//  out_valid  out  1   out_f valid
//  out_ready  in   1   downstream accepts out_f
//  out_f      out  32  round-function result f
// BEHAVIOUR
//  - Reset: out_valid=0, out_f=0, s_en=0, s*_addr=0, internal valids/type/I=0; in-flight ops discarded.
//  - Global advance adv = !out_valid | out_ready; in_ready = adv (combinational). Accept = in_valid & adv.
//  - Stalls freeze every stage together; no bubbles are inserted.
//  - Stage A (PIPE_I=1): on adv, regA <= {valid, type, I}. Addresses = regA.I; s_en = adv & regA.valid.
//    PIPE_I=0: addresses from combinational I; s_en = accept.
//  - I: type1 t=Km+D, type2 t=Km^D, type3 t=Km-D, all mod 2^32; I = cast5_rol(Kr, t).
//  - Stage B: on adv, regB <= {valid, type} of the stage issuing s_en; S-data consumed directly from ROM ports.
//  - Stage C: on adv, out_valid <= regB.valid, out_f <= combine(regB.type, S1..S4):
//    type1: ((S1^S2)-S3)+S4   type2: ((S1-S2)+S3)^S4   type3: ((S1+S2)^S3)-S4   (mod 2^32, left to right).
//  - out_f/out_valid stable while out_valid=1 & out_ready=0; ROM hold requirement keeps stage-B data intact.
//  - Latency accept->out_valid: 3 cycles (PIPE_I=1), 2 (PIPE_I=0). Back-to-back accepts give back-to-back outputs.
//  - Reserved type 11 computes exactly as type1; no error flag.
//  - Kr=0 passes t unchanged; Kr=31 equals rotate-right by 1.
//  - Reset asserted mid-stream: all valids clear in that cycle; in_ready=1 the cycle after reset deasserts.
// TESTING  (bench ROM model: Sk[a] = k<<24 | a, 1-cycle latency, holds on s_en=0; PIPE_I=1 unless noted)
//  1. type1, D=0x80000000, Km=0x80000000, Kr=0 -> addr all 0x00, out_f=0x04000000 at cycle 3 after accept.
//  2. type2, D=0x00000001, Km=0, Kr=4 -> s4_addr=0x10, others 0x00, out_f=0x06000010.
//  3. type2, D=0x00000001, Km=0, Kr=31 -> s1_addr=0x80, out_f=0x06000080 (rotate wrap-around).
//  4. type3, D=0x00000001, Km=0, Kr=31 -> t=0xFFFFFFFF, addr all 0xFF, out_f=0xFC000002 (sub borrow).
//  5. Stream tests 1-4 back-to-back, out_ready low 3 cycles on 2nd result -> in_ready=0 during stall,
//     out_f held at 0x06000010, all four results in order, no loss/duplication; repeat with PIPE_I=0 (latency 2).
//  6. Assert rst with 2 ops in flight -> out_valid=0, s_en=0 next cycle; no stale output after release.

Source files
------------

// File: rtl/cast5_fround_if.sv
// Upstream handshake, S-box ROM port and downstream result signals of the CAST5 f stage.
// The slave modport is the f stage itself; master is the surrounding logic / ROMs.
interface cast5_fround_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_type;
  logic [31:0] in_d;
  logic [31:0] in_km;
  logic [4:0]  in_kr;

  logic        s_en;
  logic [7:0]  s1_addr;
  logic [7:0]  s2_addr;
  logic [7:0]  s3_addr;
  logic [7:0]  s4_addr;
  logic [31:0] s1_data;
  logic [31:0] s2_data;
  logic [31:0] s3_data;
  logic [31:0] s4_data;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_f;

  modport master (
    output in_valid, in_type, in_d, in_km, in_kr,
    input  in_ready,
    input  s_en, s1_addr, s2_addr, s3_addr, s4_addr,
    output s1_data, s2_data, s3_data, s4_data,
    input  out_valid, out_f,
    output out_ready
  );

  modport slave (
    input  in_valid, in_type, in_d, in_km, in_kr,
    output in_ready,
    output s_en, s1_addr, s2_addr, s3_addr, s4_addr,
    input  s1_data, s2_data, s3_data, s4_data,
    output out_valid, out_f,
    input  out_ready
  );
endinterface

// File: rtl/cast5_fround.sv
// CAST5 round function f: I = (Km op D) <<< Kr, S-box lookups on the bytes of I,
// then the per-type S-box combine. One op per clock, whole pipe stalls together.
module cast5_fround #(
  parameter bit PIPE_I = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  cast5_fround_if.slave bus
);

  typedef enum logic [1:0] {
    RT_TYPE1 = 2'b00,
    RT_TYPE2 = 2'b01,
    RT_TYPE3 = 2'b10,
    RT_RSVD  = 2'b11
  } rtype_e;

  function automatic logic [31:0] cast5_rol(input logic [4:0] kr, input logic [31:0] x);
    logic [63:0] w;
    w = {x, x} << kr;
    return w[63:32];
  endfunction

  // Reserved type falls through to the type1 arithmetic.
  function automatic logic [31:0] mask_op(input rtype_e t, input logic [31:0] d,
                                          input logic [31:0] km);
    logic [31:0] r;
    case (t)
      RT_TYPE2: r = km ^ d;
      RT_TYPE3: r = km - d;
      default:  r = km + d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] combine(input rtype_e t,
                                          input logic [31:0] s1, input logic [31:0] s2,
                                          input logic [31:0] s3, input logic [31:0] s4);
    logic [31:0] r;
    case (t)
      RT_TYPE2: r = ((s1 - s2) + s3) ^ s4;
      RT_TYPE3: r = ((s1 + s2) ^ s3) - s4;
      default:  r = ((s1 ^ s2) - s3) + s4;
    endcase
    return r;
  endfunction

  logic        adv;
  logic        accept;
  logic [31:0] i_comb;

  logic        iss_valid;
  rtype_e      iss_type;
  logic [31:0] iss_i;
  logic        s_en;

  logic        b_valid;
  rtype_e      b_type;
  logic        out_valid_r;
  logic [31:0] out_f_r;

  assign adv          = !out_valid_r | bus.out_ready;
  assign accept       = bus.in_valid & adv;
  assign bus.in_ready = adv;
  assign i_comb       = cast5_rol(bus.in_kr, mask_op(rtype_e'(bus.in_type), bus.in_d, bus.in_km));

  generate
    if (PIPE_I) begin : g_pipe_i
      logic        a_valid;
      rtype_e      a_type;
      logic [31:0] a_i;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_valid <= 1'b0;
          a_type  <= RT_TYPE1;
          a_i     <= '0;
        end else if (adv) begin
          a_valid <= bus.in_valid;
          if (accept) begin
            a_type <= rtype_e'(bus.in_type);
            a_i    <= i_comb;
          end
        end
      end

      assign iss_valid = a_valid;
      assign iss_type  = a_type;
      assign iss_i     = a_i;
      assign s_en      = adv & a_valid;
    end else begin : g_direct_i
      assign iss_valid = bus.in_valid;
      assign iss_type  = rtype_e'(bus.in_type);
      assign iss_i     = i_comb;
      assign s_en      = accept;
    end
  endgenerate

  assign bus.s_en    = s_en;
  assign bus.s1_addr = iss_i[31:24];
  assign bus.s2_addr = iss_i[23:16];
  assign bus.s3_addr = iss_i[15:8];
  assign bus.s4_addr = iss_i[7:0];

  // ROM data is only read on advance; during a stall s_en is low so the ROMs hold it.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_valid     <= 1'b0;
      b_type      <= RT_TYPE1;
      out_valid_r <= 1'b0;
      out_f_r     <= '0;
    end else if (adv) begin
      b_valid     <= iss_valid;
      b_type      <= iss_type;
      out_valid_r <= b_valid;
      if (b_valid) begin
        out_f_r <= combine(b_type, bus.s1_data, bus.s2_data, bus.s3_data, bus.s4_data);
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_f     = out_f_r;

endmodule

// File: tb/tb_cast5_fround.sv
// Scoreboard bench for cast5_fround: one instance per PIPE_I setting sharing a stimulus
// driver, each with a 1-cycle S-box ROM model Sk[a] = k<<24 | a.
module tb_cast5_fround;

  typedef struct {
    logic [31:0] f;
    int          acc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        in_valid;
  logic [1:0]  in_type;
  logic [31:0] in_d;
  logic [31:0] in_km;
  logic [4:0]  in_kr;
  logic        out_ready;

  logic        cur_in_ready;
  logic        cur_out_valid;
  logic        cur_s_en;
  logic [31:0] cur_out_f;
  logic [31:0] cur_addr;

  int          checks = 0;
  int          failures = 0;
  int          cycle = 0;
  int          pop_count = 0;
  int          stall_left = 0;
  int          first_lat = 0;
  logic        accepted;
  logic [31:0] cur_exp;
  exp_t        sbq[$];

  logic [1:0]  op_type[8];
  logic [31:0] op_d[8];
  logic [31:0] op_km[8];
  logic [4:0]  op_kr[8];
  logic [31:0] op_f[8];

  cast5_fround_if bus1();
  cast5_fround_if bus0();

  cast5_fround #(.PIPE_I(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  cast5_fround #(.PIPE_I(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus1.in_valid  = in_valid & sel;
  assign bus1.in_type   = in_type;
  assign bus1.in_d      = in_d;
  assign bus1.in_km     = in_km;
  assign bus1.in_kr     = in_kr;
  assign bus1.out_ready = out_ready;
  assign bus0.in_valid  = in_valid & ~sel;
  assign bus0.in_type   = in_type;
  assign bus0.in_d      = in_d;
  assign bus0.in_km     = in_km;
  assign bus0.in_kr     = in_kr;
  assign bus0.out_ready = out_ready;

  always @(posedge clk) begin
    if (bus1.s_en) begin
      bus1.s1_data <= {8'd1, 16'd0, bus1.s1_addr};
      bus1.s2_data <= {8'd2, 16'd0, bus1.s2_addr};
      bus1.s3_data <= {8'd3, 16'd0, bus1.s3_addr};
      bus1.s4_data <= {8'd4, 16'd0, bus1.s4_addr};
    end
    if (bus0.s_en) begin
      bus0.s1_data <= {8'd1, 16'd0, bus0.s1_addr};
      bus0.s2_data <= {8'd2, 16'd0, bus0.s2_addr};
      bus0.s3_data <= {8'd3, 16'd0, bus0.s3_addr};
      bus0.s4_data <= {8'd4, 16'd0, bus0.s4_addr};
    end
  end

  assign cur_in_ready  = sel ? bus1.in_ready  : bus0.in_ready;
  assign cur_out_valid = sel ? bus1.out_valid : bus0.out_valid;
  assign cur_s_en      = sel ? bus1.s_en      : bus0.s_en;
  assign cur_out_f     = sel ? bus1.out_f     : bus0.out_f;
  assign cur_addr      = sel ? {bus1.s1_addr, bus1.s2_addr, bus1.s3_addr, bus1.s4_addr}
                             : {bus0.s1_addr, bus0.s2_addr, bus0.s3_addr, bus0.s4_addr};

  // Reference f built from the textual definition and the ROM contents.
  function automatic logic [31:0] model_f(input logic [1:0] t, input logic [31:0] d,
                                          input logic [31:0] km, input logic [4:0] kr);
    logic [31:0] x, i, s1, s2, s3, s4;
    logic [63:0] w;
    if (t == 2'b01)      x = km ^ d;
    else if (t == 2'b10) x = km - d;
    else                 x = km + d;
    w  = ({32'd0, x} << kr) | ({32'd0, x} << (kr + 6'd32));
    i  = w[63:32] | w[31:0];
    i  = (kr == 5'd0) ? x : (x << kr) | (x >> (6'd32 - {1'b0, kr}));
    s1 = 32'h01000000 | {24'd0, i[31:24]};
    s2 = 32'h02000000 | {24'd0, i[23:16]};
    s3 = 32'h03000000 | {24'd0, i[15:8]};
    s4 = 32'h04000000 | {24'd0, i[7:0]};
    if (t == 2'b01)      return ((s1 - s2) + s3) ^ s4;
    else if (t == 2'b10) return ((s1 + s2) ^ s3) - s4;
    else                 return ((s1 ^ s2) - s3) + s4;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int idx);
    in_type  = op_type[idx];
    in_d     = op_d[idx];
    in_km    = op_km[idx];
    in_kr    = op_kr[idx];
    cur_exp  = op_f[idx];
    in_valid = 1'b1;
  endtask

  // One clock: settle, handle both handshakes at the sample point, then advance.
  task automatic step();
    exp_t e;
    logic stalling;
    #1;
    stalling  = (stall_left > 0) && (cur_out_valid === 1'b1) && (pop_count == 1);
    out_ready = !stalling;
    #1;
    if (stalling) begin
      stall_left--;
      check_output("stall_in_ready", {31'd0, cur_in_ready}, 32'd0);
      check_output("stall_hold_f", cur_out_f, 32'h06000010);
    end
    accepted = in_valid && (cur_in_ready === 1'b1);
    if (accepted) sbq.push_back('{f: cur_exp, acc: cycle});
    if ((cur_out_valid === 1'b1) && out_ready) begin
      check_output("sb_nonempty", {31'd0, sbq.size() > 0}, 32'd1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check_output("out_f", cur_out_f, e.f);
        if (pop_count == 0) first_lat = cycle - e.acc;
        pop_count++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cycle++;
  endtask

  task automatic drain();
    int g = 0;
    while (sbq.size() > 0 && g < 40) begin
      step();
      g++;
    end
    check_output("drain_timeout", sbq.size(), 32'd0);
  endtask

  task automatic run_single(input int idx, input logic [31:0] exp_addr);
    pop_count = 0;
    apply_stimulus(idx);
    step();
    check_output("single_accept", {31'd0, accepted}, 32'd1);
    in_valid = 1'b0;
    #1;
    check_output("single_s_en", {31'd0, cur_s_en}, 32'd1);
    check_output("single_addr", cur_addr, exp_addr);
    drain();
    check_output("single_latency", first_lat, 32'd3);
  endtask

  task automatic run_stream(input int first, input int n_ops, input int stall);
    int idx = first;
    int guard = 0;
    pop_count  = 0;
    stall_left = stall;
    while (idx < first + n_ops && guard < 100) begin
      apply_stimulus(idx);
      step();
      if (accepted) idx++;
      guard++;
    end
    in_valid = 1'b0;
    drain();
    check_output("stream_count", pop_count, n_ops);
  endtask

  initial begin
    op_type[0] = 2'b00; op_d[0] = 32'h80000000; op_km[0] = 32'h80000000; op_kr[0] = 5'd0;
    op_f[0] = 32'h04000000;
    op_type[1] = 2'b01; op_d[1] = 32'h00000001; op_km[1] = 32'h0; op_kr[1] = 5'd4;
    op_f[1] = 32'h06000010;
    op_type[2] = 2'b01; op_d[2] = 32'h00000001; op_km[2] = 32'h0; op_kr[2] = 5'd31;
    op_f[2] = 32'h06000080;
    op_type[3] = 2'b10; op_d[3] = 32'h00000001; op_km[3] = 32'h0; op_kr[3] = 5'd31;
    op_f[3] = 32'hFC000002;
    for (int i = 4; i < 8; i++) begin
      op_type[i] = (i == 4) ? 2'b11 : 2'($urandom_range(0, 3));
      op_d[i]    = $urandom;
      op_km[i]   = $urandom;
      op_kr[i]   = 5'($urandom_range(0, 31));
      op_f[i]    = model_f(op_type[i], op_d[i], op_km[i], op_kr[i]);
    end

    sel = 1'b1; rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_type = 2'b00; in_d = '0; in_km = '0; in_kr = '0; cur_exp = '0;
    @(negedge clk);
    step(); step(); step();
    #1;
    check_output("rst_out_valid", {31'd0, bus1.out_valid}, 32'd0);
    check_output("rst_out_f", bus1.out_f, 32'd0);
    check_output("rst_s_en", {31'd0, bus1.s_en}, 32'd0);
    check_output("rst_addr", {bus1.s1_addr, bus1.s2_addr, bus1.s3_addr, bus1.s4_addr}, 32'd0);
    check_output("rst_out_valid_p0", {31'd0, bus0.out_valid}, 32'd0);
    rst = 1'b0;
    step();

    $display("[TB] single ops, PIPE_I=1");
    run_single(0, 32'h00000000);
    run_single(1, 32'h00000010);
    run_single(2, 32'h80000000);
    run_single(3, 32'hFFFFFFFF);

    $display("[TB] stream with stall on second result, PIPE_I=1");
    run_stream(0, 4, 3);
    check_output("stream_latency_p1", first_lat, 32'd3);
    run_stream(4, 4, 0);

    $display("[TB] stream with stall on second result, PIPE_I=0");
    sel = 1'b0;
    step();
    run_stream(0, 4, 3);
    check_output("stream_latency_p0", first_lat, 32'd2);
    run_stream(4, 4, 0);

    $display("[TB] reset with ops in flight, PIPE_I=1");
    sel = 1'b1;
    step();
    pop_count = 0;
    apply_stimulus(0); step();
    apply_stimulus(1); step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    sbq.delete();
    #2;
    check_output("midrst_out_valid", {31'd0, cur_out_valid}, 32'd0);
    check_output("midrst_s_en", {31'd0, cur_s_en}, 32'd0);
    check_output("midrst_in_ready", {31'd0, cur_in_ready}, 32'd1);
    for (int k = 0; k < 6; k++) step();
    check_output("midrst_no_stale", pop_count, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
